// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: operation encoding, bus access size and
// a decoder that splits a memop into size / direction / signedness.
package mem_stage_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef logic [XLEN-1:0] u64;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD
    } memop_t;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2,
        MSIZE_D = 2'd3
    } msize_t;

    typedef struct packed {
        msize_t size;
        logic   is_load;
        logic   is_store;
        logic   is_signed;
    } memop_info_t;

    function automatic memop_info_t decode_memop(input memop_t op);
        memop_info_t info;
        info.size      = MSIZE_B;
        info.is_load   = 1'b0;
        info.is_store  = 1'b0;
        info.is_signed = 1'b0;
        case (op)
            LB:  begin info.size = MSIZE_B; info.is_load = 1'b1; info.is_signed = 1'b1; end
            LH:  begin info.size = MSIZE_H; info.is_load = 1'b1; info.is_signed = 1'b1; end
            LW:  begin info.size = MSIZE_W; info.is_load = 1'b1; info.is_signed = 1'b1; end
            LD:  begin info.size = MSIZE_D; info.is_load = 1'b1; end
            LBU: begin info.size = MSIZE_B; info.is_load = 1'b1; end
            LHU: begin info.size = MSIZE_H; info.is_load = 1'b1; end
            LWU: begin info.size = MSIZE_W; info.is_load = 1'b1; end
            SB:  begin info.size = MSIZE_B; info.is_store = 1'b1; end
            SH:  begin info.size = MSIZE_H; info.is_store = 1'b1; end
            SW:  begin info.size = MSIZE_W; info.is_store = 1'b1; end
            SD:  begin info.size = MSIZE_D; info.is_store = 1'b1; end
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: misalignment check, store strobe/data
// placement and load data extraction with sign/zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  memop_t     i_memop,
    input  logic [2:0] i_offset,
    input  u64         i_sdata,
    input  u64         i_rdata,
    output logic       o_is_mem,
    output logic       o_is_load,
    output msize_t     o_size,
    output logic       o_misalign,
    output logic [7:0] o_strobe,
    output u64         o_wdata,
    output u64         o_ldata
);

    memop_info_t w_info;
    logic [5:0]  w_shamt;
    logic [7:0]  w_size_mask;
    logic [2:0]  w_align_mask;
    u64          w_rshift;

    always_comb begin
        w_info   = decode_memop(i_memop);
        w_shamt  = {i_offset, 3'b000};
        w_rshift = i_rdata >> w_shamt;

        case (w_info.size)
            MSIZE_B: begin w_size_mask = 8'h01; w_align_mask = 3'b000; end
            MSIZE_H: begin w_size_mask = 8'h03; w_align_mask = 3'b001; end
            MSIZE_W: begin w_size_mask = 8'h0F; w_align_mask = 3'b011; end
            default: begin w_size_mask = 8'hFF; w_align_mask = 3'b111; end
        endcase

        o_is_mem   = w_info.is_load || w_info.is_store;
        o_is_load  = w_info.is_load;
        o_size     = w_info.size;
        o_misalign = o_is_mem && ((i_offset & w_align_mask) != 3'b000);

        // Loads leave strobe and write data at zero so nothing is written.
        o_strobe = w_info.is_store ? (w_size_mask << i_offset) : 8'h00;
        o_wdata  = w_info.is_store ? (i_sdata << w_shamt) : '0;

        case (w_info.size)
            MSIZE_B: o_ldata = w_info.is_signed ? {{56{w_rshift[7]}},  w_rshift[7:0]}
                                                : {56'd0, w_rshift[7:0]};
            MSIZE_H: o_ldata = w_info.is_signed ? {{48{w_rshift[15]}}, w_rshift[15:0]}
                                                : {48'd0, w_rshift[15:0]};
            MSIZE_W: o_ldata = w_info.is_signed ? {{32{w_rshift[31]}}, w_rshift[31:0]}
                                                : {32'd0, w_rshift[31:0]};
            default: o_ldata = w_rshift;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-bus request per memory op, aligns
// load data and holds a single registered writeback record.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  u64               in_result,
    input  memop_t           in_memop,
    input  u64               in_sdata,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output u64               out_result,
    output logic [REG_W-1:0] out_rd,
    output logic             out_wen,
    output logic             out_misalign,
    output logic             dreq_valid,
    output u64               dreq_addr,
    output msize_t           dreq_size,
    output logic [7:0]       dreq_strobe,
    output u64               dreq_data,
    input  logic             dresp_data_ok,
    input  u64               dresp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    memop_t           r_memop;
    logic             r_is_load;
    logic [REG_W-1:0] r_rd;
    logic             r_wen;

    logic             r_out_valid;
    u64               r_out_result;
    logic [REG_W-1:0] r_out_rd;
    logic             r_out_wen;
    logic             r_out_misalign;

    logic             r_dreq_valid;
    u64               r_dreq_addr;
    msize_t           r_dreq_size;
    logic [7:0]       r_dreq_strobe;
    u64               r_dreq_data;

    logic             w_in_fire;
    memop_t           w_al_memop;
    logic [2:0]       w_al_offset;
    logic             w_is_mem;
    logic             w_is_load;
    msize_t           w_size;
    logic             w_misalign;
    logic [7:0]       w_strobe;
    u64               w_wdata;
    u64               w_ldata;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_in_fire = in_valid && in_ready;

    // While a request is outstanding no input can be accepted, so the single
    // aligner serves the held op in REQ and the incoming op otherwise.
    assign w_al_memop  = (r_state == S_REQ) ? r_memop : in_memop;
    assign w_al_offset = (r_state == S_REQ) ? r_dreq_addr[2:0] : in_result[2:0];

    mem_align u_align (
        .i_memop    (w_al_memop),
        .i_offset   (w_al_offset),
        .i_sdata    (in_sdata),
        .i_rdata    (dresp_data),
        .o_is_mem   (w_is_mem),
        .o_is_load  (w_is_load),
        .o_size     (w_size),
        .o_misalign (w_misalign),
        .o_strobe   (w_strobe),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_memop        <= MEM_NONE;
            r_is_load      <= 1'b0;
            r_rd           <= '0;
            r_wen          <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_rd       <= '0;
            r_out_wen      <= 1'b0;
            r_out_misalign <= 1'b0;
            r_dreq_valid   <= 1'b0;
            r_dreq_addr    <= '0;
            r_dreq_size    <= MSIZE_B;
            r_dreq_strobe  <= '0;
            r_dreq_data    <= '0;
        end else if (w_in_fire) begin
            r_memop   <= in_memop;
            r_is_load <= w_is_load;
            r_rd      <= in_rd;
            r_wen     <= in_wen;
            if (!w_is_mem) begin
                r_state        <= S_DONE;
                r_out_valid    <= 1'b1;
                r_out_result   <= in_result;
                r_out_rd       <= in_rd;
                r_out_wen      <= in_wen;
                r_out_misalign <= 1'b0;
            end else if (w_misalign) begin
                r_state        <= S_DONE;
                r_out_valid    <= 1'b1;
                r_out_result   <= in_result;
                r_out_rd       <= in_rd;
                r_out_wen      <= 1'b0;
                r_out_misalign <= 1'b1;
            end else begin
                r_state       <= S_REQ;
                r_out_valid   <= 1'b0;
                r_dreq_valid  <= 1'b1;
                r_dreq_addr   <= in_result;
                r_dreq_size   <= w_size;
                r_dreq_strobe <= w_strobe;
                r_dreq_data   <= w_wdata;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (dresp_data_ok) begin
                        r_state        <= S_DONE;
                        r_dreq_valid   <= 1'b0;
                        r_out_valid    <= 1'b1;
                        r_out_result   <= r_is_load ? w_ldata : r_dreq_addr;
                        r_out_rd       <= r_rd;
                        r_out_wen      <= r_is_load && r_wen;
                        r_out_misalign <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_rd       = r_out_rd;
    assign out_wen      = r_out_wen;
    assign out_misalign = r_out_misalign;
    assign dreq_valid   = r_dreq_valid;
    assign dreq_addr    = r_dreq_addr;
    assign dreq_size    = r_dreq_size;
    assign dreq_strobe  = r_dreq_strobe;
    assign dreq_data    = r_dreq_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    memop_t      in_memop;
    logic [63:0] in_sdata;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_misalign;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    msize_t      dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_memop      (in_memop),
        .in_sdata      (in_sdata),
        .in_rd         (in_rd),
        .in_wen        (in_wen),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_misalign  (out_misalign),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    // Reference model: byte count, lane placement and extension by plain arithmetic.
    function automatic int op_bytes(input memop_t op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            LD, SD:      return 8;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [1:0] size_code(input int nb);
        if (nb == 1) return 2'd0;
        if (nb == 2) return 2'd1;
        if (nb == 4) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [63:0] model_load(input memop_t op, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int nb = op_bytes(op);
        int off = int'(addr[2:0]);
        logic [63:0] v = rdata >> (8 * off);
        logic [63:0] mask;
        if (nb < 8) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v = v & mask;
            if ((op inside {LB, LH, LW}) && v[8 * nb - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_strobe(input int nb, input logic [63:0] addr);
        logic [15:0] s = ((16'd1 << nb) - 16'd1) << addr[2:0];
        return s[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_result = '0; in_memop = MEM_NONE; in_sdata = '0;
        in_rd = '0; in_wen = 1'b0; out_ready = 1'b1; dresp_data_ok = 1'b0; dresp_data = '0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_result !== 64'd0) begin errors++; $display("FAIL rst_out_result: got %h want 0", out_result); end
        checks++; if ({out_rd, out_wen, out_misalign} !== 7'd0) begin errors++; $display("FAIL rst_out_ctl: got %h want 0", {out_rd, out_wen, out_misalign}); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rst_dreq_valid: got %b want 0", dreq_valid); end
        checks++; if ({dreq_addr, dreq_size, dreq_strobe, dreq_data} !== 138'd0) begin errors++; $display("FAIL rst_dreq_fields: addr %h strobe %h data %h want 0", dreq_addr, dreq_strobe, dreq_data); end
    endtask

    task automatic test_passthrough();
        logic [63:0] vals[4];
        logic [4:0]  rds[4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = {$urandom, $urandom};
            rds[i]  = 5'($urandom_range(1, 31));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_memop = MEM_NONE; in_result = vals[i]; in_rd = rds[i]; in_wen = 1'b1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pt_in_ready[%0d]: got %b want 1", i, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_out_valid[%0d]: got %b want 1", i - 1, out_valid); end
                checks++; if (out_result !== vals[i-1]) begin errors++; $display("FAIL pt_result[%0d]: got %h want %h", i - 1, out_result, vals[i-1]); end
                checks++; if (out_rd !== rds[i-1] || out_wen !== 1'b1) begin errors++; $display("FAIL pt_rd_wen[%0d]: got %0d/%b want %0d/1", i - 1, out_rd, out_wen, rds[i-1]); end
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pt_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_lb_sign();
        in_valid = 1'b1; in_memop = LB; in_result = 64'h1003; in_sdata = {$urandom, $urandom};
        in_rd = 5'd7; in_wen = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1003) begin errors++; $display("FAIL lb_req: valid %b addr %h want 1/1003", dreq_valid, dreq_addr); end
        checks++; if (dreq_size !== MSIZE_B || dreq_strobe !== 8'h00) begin errors++; $display("FAIL lb_size_strobe: got %0d/%h want 0/00", dreq_size, dreq_strobe); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (dreq_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL lb_wait[%0d]: dreq_valid %b out_valid %b want 1/0", c, dreq_valid, out_valid); end
        end
        dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_8000_0000;
        step();
        dresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_result: valid %b got %h want FFFFFFFFFFFFFF80", out_valid, out_result); end
        checks++; if (out_wen !== 1'b1 || out_rd !== 5'd7 || dreq_valid !== 1'b0) begin errors++; $display("FAIL lb_ctl: wen %b rd %0d dreq %b want 1/7/0", out_wen, out_rd, dreq_valid); end
        step();
    endtask

    task automatic test_sh_store();
        in_valid = 1'b1; in_memop = SH; in_result = 64'h2006; in_sdata = 64'h1234;
        in_rd = 5'd3; in_wen = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_sdata = {$urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            checks++; if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hC0) begin errors++; $display("FAIL sh_strobe[%0d]: valid %b strobe %h want 1/C0", c, dreq_valid, dreq_strobe); end
            checks++; if (dreq_data !== 64'h1234_0000_0000_0000 || dreq_addr !== 64'h2006 || dreq_size !== MSIZE_H) begin errors++; $display("FAIL sh_data[%0d]: data %h addr %h size %0d", c, dreq_data, dreq_addr, dreq_size); end
            if (c == 2) begin dresp_data_ok = 1'b1; dresp_data = {$urandom, $urandom}; end
            step();
        end
        dresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_result !== 64'h2006) begin errors++; $display("FAIL sh_out: valid %b wen %b result %h want 1/0/2006", out_valid, out_wen, out_result); end
        step();
    endtask

    task automatic test_misalign();
        in_valid = 1'b1; in_memop = LW; in_result = 64'h3002; in_rd = 5'd9; in_wen = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL mis_dreq: got %b want 0", dreq_valid); end
        checks++; if (out_valid !== 1'b1 || out_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag: valid %b misalign %b want 1/1", out_valid, out_misalign); end
        checks++; if (out_result !== 64'h3002 || out_wen !== 1'b0) begin errors++; $display("FAIL mis_result: got %h wen %b want 3002/0", out_result, out_wen); end
        step();
        checks++; if (dreq_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_after: dreq %b out_valid %b want 0/0", dreq_valid, out_valid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] rdata = {$urandom, $urandom};
        logic [63:0] exp_ld = {32'd0, rdata[63:32]};
        logic [63:0] nxt = {$urandom, $urandom};
        in_valid = 1'b1; in_memop = LWU; in_result = 64'h4004; in_rd = 5'd11; in_wen = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = rdata; out_ready = 1'b0;
        step();
        dresp_data_ok = 1'b0; dresp_data = '0;
        in_valid = 1'b1; in_memop = MEM_NONE; in_result = nxt; in_rd = 5'd12; in_wen = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== exp_ld) begin errors++; $display("FAIL bp_hold[%0d]: valid %b got %h want %h", c, out_valid, out_result, exp_ld); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== nxt || out_rd !== 5'd12) begin errors++; $display("FAIL bp_next: valid %b got %h rd %0d want %h/12", out_valid, out_result, out_rd, nxt); end
        step();
    endtask

    task automatic test_reset_req();
        in_valid = 1'b1; in_memop = LD; in_result = 64'h5008; in_rd = 5'd5; in_wen = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL rr_req: got %b want 1", dreq_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rr_drop: dreq_valid %b want 0", dreq_valid); end
        checks++; if ({out_valid, out_result, out_rd, out_wen, out_misalign} !== 72'd0) begin errors++; $display("FAIL rr_out_zero: valid %b result %h rd %0d", out_valid, out_result, out_rd); end
        checks++; if ({dreq_addr, dreq_strobe, dreq_data} !== 136'd0) begin errors++; $display("FAIL rr_dreq_zero: addr %h strobe %h data %h", dreq_addr, dreq_strobe, dreq_data); end
        step();
        reset = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = {$urandom, $urandom};
        step();
        dresp_data_ok = 1'b0;
        checks++; if (out_valid !== 1'b0 || dreq_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rr_ignore_ok: out_valid %b dreq %b in_ready %b want 0/0/1", out_valid, dreq_valid, in_ready); end
    endtask

    task automatic test_random();
        memop_t      op;
        logic [63:0] addr, sdata, rdata, exp_res;
        logic [4:0]  rd;
        logic        wen, is_mem, mis, is_ld, exp_wen;
        int          nb, lat, bp;
        for (int n = 0; n < 60; n++) begin
            op    = memop_t'(4'($urandom_range(0, 11)));
            addr  = {$urandom, $urandom};
            sdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rd    = 5'($urandom);
            wen   = 1'($urandom);
            lat   = $urandom_range(0, 3);
            bp    = $urandom_range(0, 2);
            nb     = op_bytes(op);
            is_mem = (nb != 0);
            is_ld  = op inside {LB, LH, LW, LD, LBU, LHU, LWU};
            mis    = is_mem && ((int'(addr[2:0]) % nb) != 0);
            if (!is_mem)             begin exp_res = addr; exp_wen = wen; end
            else if (mis || !is_ld)  begin exp_res = addr; exp_wen = 1'b0; end
            else                     begin exp_res = model_load(op, addr, rdata); exp_wen = wen; end

            out_ready = 1'b1;
            in_valid = 1'b1; in_memop = op; in_result = addr; in_sdata = sdata; in_rd = rd; in_wen = wen;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want 1", n, in_ready); end
            step();
            in_valid = 1'b0;
            if (is_mem && !mis) begin
                checks++; if (dreq_valid !== 1'b1 || dreq_addr !== addr || dreq_size !== msize_t'(size_code(nb))) begin errors++; $display("FAIL rnd_req[%0d]: valid %b addr %h size %0d want 1/%h/%0d", n, dreq_valid, dreq_addr, dreq_size, addr, size_code(nb)); end
                checks++; if (dreq_strobe !== (is_ld ? 8'h00 : model_strobe(nb, addr))) begin errors++; $display("FAIL rnd_strobe[%0d]: got %h op %0d addr %h", n, dreq_strobe, op, addr); end
                if (!is_ld) begin
                    checks++; if (dreq_data !== (sdata << (8 * int'(addr[2:0])))) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, dreq_data, sdata << (8 * int'(addr[2:0]))); end
                end
                for (int c = 0; c < lat; c++) begin
                    step();
                    checks++; if (dreq_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_wait[%0d]: dreq %b out_valid %b want 1/0", n, dreq_valid, out_valid); end
                end
                dresp_data_ok = 1'b1; dresp_data = rdata;
                step();
                dresp_data_ok = 1'b0; dresp_data = '0;
            end else begin
                checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rnd_noreq[%0d]: got %b want 0", n, dreq_valid); end
            end
            out_ready = (bp == 0);
            checks++; if (out_valid !== 1'b1 || out_result !== exp_res) begin errors++; $display("FAIL rnd_result[%0d]: op %0d addr %h got %h want %h", n, op, addr, out_result, exp_res); end
            checks++; if (out_wen !== exp_wen || out_rd !== rd || out_misalign !== mis) begin errors++; $display("FAIL rnd_ctl[%0d]: wen %b rd %0d mis %b want %b/%0d/%b", n, out_wen, out_rd, out_misalign, exp_wen, rd, mis); end
            for (int c = 0; c < bp; c++) begin
                step();
                if (c == bp - 1) out_ready = 1'b1;
                checks++; if (out_valid !== 1'b1 || out_result !== exp_res) begin errors++; $display("FAIL rnd_hold[%0d]: valid %b got %h want %h", n, out_valid, out_result, exp_res); end
            end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain[%0d]: out_valid %b want 0", n, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_lb_sign();
        test_sh_store();
        test_misalign();
        test_backpressure();
        test_reset_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
